// File: rtl/score_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// score_sequencer : queues line-clear events and accumulates a BCD score,
// a BCD lines-cleared total and a binary level.        Revision 1.0
// ----------------------------------------------------------------------------
module score_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        ev_valid,
  input  logic [1:0]  ev_lines,
  output logic        ev_ready,
  output logic [11:0] score,
  output logic [11:0] lines_total,
  output logic [3:0]  level,
  output logic        busy,
  output logic        commit,
  output logic        sat
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ADD0  = 2'd1;
  localparam logic [1:0] C_ADD1  = 2'd2;
  localparam logic [1:0] C_ADD2  = 2'd3;
  localparam logic [2:0] C_DEPTH = 3'd4;

  logic [1:0]  state_q, state_d;
  logic [1:0]  fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic [11:0] op_q;
  logic [1:0]  op_lines_q;
  logic [7:0]  shadow_q;
  logic        carry_q;
  logic [11:0] score_q, lines_q;
  logic [3:0]  level_q;
  logic        sat_q, commit_q;

  logic        w_push, w_pop, w_add, w_commit;
  logic [1:0]  w_pop_lines;
  logic [11:0] w_pop_points;
  logic [3:0]  w_op_dig, w_sc_dig, w_sum_dig;
  logic [4:0]  w_sum_raw;
  logic        w_cout;
  logic [4:0]  w_ld0, w_ld1, w_ld2;
  logic [11:0] w_lines_next;

  assign ev_ready    = (count_q != C_DEPTH);
  assign busy        = (count_q != 3'd0) || (state_q != C_IDLE);
  assign score       = score_q;
  assign lines_total = lines_q;
  assign level       = level_q;
  assign sat         = sat_q;
  assign commit      = commit_q;
  assign w_push      = ev_valid & ev_ready & ~clr;

  // FIFO storage carries no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (w_push) fifo_q[wr_ptr_q] <= ev_lines;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else if (clr) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = C_IDLE;
    end else begin
      case (state_q)
        C_IDLE:  if (count_q != 3'd0) state_d = C_ADD0;
        C_ADD0:  state_d = C_ADD1;
        C_ADD1:  state_d = C_ADD2;
        default: state_d = C_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pop    = 1'b0;
    w_add    = 1'b0;
    w_commit = 1'b0;
    if (!clr) begin
      case (state_q)
        C_IDLE:  w_pop    = (count_q != 3'd0);
        C_ADD0:  w_add    = 1'b1;
        C_ADD1:  w_add    = 1'b1;
        default: w_commit = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_pop_lines = fifo_q[rd_ptr_q];
    case (w_pop_lines)
      2'd0:    w_pop_points = 12'h001;
      2'd1:    w_pop_points = 12'h004;
      2'd2:    w_pop_points = 12'h009;
      default: w_pop_points = 12'h016;
    endcase
  end

  // The single shared BCD digit adder; the FSM state selects the digit.
  always_comb begin
    case (state_q)
      C_ADD0: begin
        w_op_dig = op_q[3:0];
        w_sc_dig = score_q[3:0];
      end
      C_ADD1: begin
        w_op_dig = op_q[7:4];
        w_sc_dig = score_q[7:4];
      end
      default: begin
        w_op_dig = op_q[11:8];
        w_sc_dig = score_q[11:8];
      end
    endcase
    w_sum_raw = {1'b0, w_op_dig} + {1'b0, w_sc_dig} + {4'd0, carry_q};
    w_cout    = (w_sum_raw > 5'd9);
    w_sum_dig = w_cout ? (w_sum_raw[3:0] + 4'd6) : w_sum_raw[3:0];
  end

  // Lines total only ever grows by 1..4, so a ripple of +1 carries suffices above digit 0.
  always_comb begin
    w_ld0 = {1'b0, lines_q[3:0]} + {3'b000, op_lines_q} + 5'd1;
    w_ld1 = {1'b0, lines_q[7:4]} + {4'd0, (w_ld0 > 5'd9)};
    w_ld2 = {1'b0, lines_q[11:8]} + {4'd0, (w_ld1 > 5'd9)};
    if (w_ld2 > 5'd9) begin
      w_lines_next = 12'h999;
    end else begin
      w_lines_next = {w_ld2[3:0],
                      (w_ld1 > 5'd9) ? 4'd0 : w_ld1[3:0],
                      (w_ld0 > 5'd9) ? (w_ld0[3:0] - 4'd10) : w_ld0[3:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 12'h000;
      op_lines_q <= 2'd0;
      shadow_q   <= 8'h00;
      carry_q    <= 1'b0;
      score_q    <= 12'h000;
      lines_q    <= 12'h000;
      level_q    <= 4'd0;
      sat_q      <= 1'b0;
      commit_q   <= 1'b0;
    end else if (clr) begin
      op_q       <= 12'h000;
      op_lines_q <= 2'd0;
      shadow_q   <= 8'h00;
      carry_q    <= 1'b0;
      score_q    <= 12'h000;
      lines_q    <= 12'h000;
      level_q    <= 4'd0;
      sat_q      <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      commit_q <= w_commit;
      if (w_pop) begin
        op_q       <= w_pop_points;
        op_lines_q <= w_pop_lines;
        carry_q    <= 1'b0;
      end
      if (w_add) begin
        carry_q <= w_cout;
        if (state_q == C_ADD0) shadow_q[3:0] <= w_sum_dig;
        else                   shadow_q[7:4] <= w_sum_dig;
      end
      if (w_commit) begin
        carry_q <= 1'b0;
        if (w_cout) begin
          score_q <= 12'h999;
          sat_q   <= 1'b1;
        end else begin
          score_q <= {w_sum_dig, shadow_q};
        end
        lines_q <= w_lines_next;
        if ((w_lines_next[11:4] != lines_q[11:4]) && (level_q != 4'hF))
          level_q <= level_q + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_score_sequencer : randomized and directed bench against an arithmetic
// model of the score sequencer.                         Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_score_sequencer;

  logic        clk = 1'b0;
  logic        rst, clr, ev_valid;
  logic [1:0]  ev_lines;
  logic        ev_ready, busy, commit, sat;
  logic [11:0] score, lines_total;
  logic [3:0]  level;

  always #5 clk = ~clk;

  score_sequencer dut (
    .clk(clk), .rst(rst), .clr(clr), .ev_valid(ev_valid), .ev_lines(ev_lines),
    .ev_ready(ev_ready), .score(score), .lines_total(lines_total), .level(level),
    .busy(busy), .commit(commit), .sat(sat)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: integer score/lines/level, a queue of pending events and a
  // countdown of edges remaining until the in-flight event is committed.
  int m_score, m_lines, m_level, m_rem, m_op;
  bit m_sat, m_commit;
  int q[$];
  int commit_log[$];
  bit saw_not_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_score = 0; m_lines = 0; m_level = 0; m_rem = 0; m_op = 0;
    m_sat = 0; m_commit = 0;
  endtask

  task automatic model_edge(input bit v, input int l, input bit c);
    bit idle, acc;
    int total, nl;
    m_commit = 0;
    if (c) begin
      model_reset();
    end else begin
      idle = (m_rem == 0);
      acc  = v && (q.size() < 4);
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          total = m_score + (m_op + 1) * (m_op + 1);
          if (total > 999) begin
            m_score = 999;
            m_sat   = 1;
          end else begin
            m_score = total;
          end
          nl = m_lines + m_op + 1;
          if (nl > 999) nl = 999;
          if ((nl / 10 != m_lines / 10) && (m_level < 15)) m_level++;
          m_lines  = nl;
          m_commit = 1;
        end
      end
      if (idle && q.size() > 0) begin
        m_op  = q.pop_front();
        m_rem = 3;
      end
      if (acc) q.push_back(l);
    end
  endtask

  task automatic compare_all();
    check("score",       score,       to_bcd(m_score));
    check("lines_total", lines_total, to_bcd(m_lines));
    check("level",       level,       m_level);
    check("sat",         sat,         m_sat);
    check("commit",      commit,      m_commit);
    check("ev_ready",    ev_ready,    (q.size() < 4));
    check("busy",        busy,        (q.size() != 0) || (m_rem != 0));
  endtask

  // Called at posedge+1; drives inputs, advances one edge, then compares.
  task automatic step(input bit v, input logic [1:0] l, input bit c);
    ev_valid = v; ev_lines = l; clr = c;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else     model_edge(v, int'(l), c);
    if (commit)    commit_log.push_back(cyc);
    if (!ev_ready) saw_not_ready = 1;
    compare_all();
  endtask

  task automatic send_hold(input logic [1:0] l);
    bit acc;
    int t = 0;
    do begin
      acc = (q.size() < 4);
      step(1'b1, l, 1'b0);
      t++;
    end while (!acc && t < 50);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    ev_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (((q.size() != 0) || (m_rem != 0)) && t < 100) begin
      step(1'b0, 2'd0, 1'b0);
      t++;
    end
    check("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pts_sum;
    logic [1:0] l;
    rst = 1'b0; clr = 1'b0; ev_valid = 1'b0; ev_lines = 2'd0;
    model_reset();
    #1 rst = 1'b1;
    #1 compare_all();
    step(1'b1, 2'd3, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Single 4-line event: score 016 after E4, one commit, idle by E5.
    commit_log.delete();
    step(1'b1, 2'd3, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 2'd0, 1'b0);
      if (i == 4) check("t031_score_e4", score, 12'h016);
      if (i == 5) check("t031_busy_e5", busy, 1'b0);
    end
    check("t031_lines", lines_total, 12'h004);
    check("t031_commits", commit_log.size(), 1);

    // Four back-to-back events.
    step(1'b0, 2'd0, 1'b1);
    commit_log.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 2'd0, 1'b0);
    check("t032_score", score, 12'h030);
    check("t032_lines", lines_total, 12'h010);
    check("t032_level", level, 4'd1);
    check("t032_commits", commit_log.size(), 4);
    for (int i = 1; i < commit_log.size(); i++)
      check("t032_gap", commit_log[i] - commit_log[i-1], 4);

    // Six events held valid continuously: back-pressure must appear, none lost.
    step(1'b0, 2'd0, 1'b1);
    saw_not_ready = 0;
    pts_sum = 0;
    for (int i = 0; i < 6; i++) begin
      l = 2'($urandom_range(0, 3));
      pts_sum += (int'(l) + 1) * (int'(l) + 1);
      send_hold(l);
    end
    drain();
    check("t033_ready_low", saw_not_ready, 1'b1);
    check("t033_score", score, to_bcd(pts_sum));

    // Saturation: preload 995, then 16 points, then one more event.
    step(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 62; i++) send_hold(2'd3);
    for (int i = 0; i < 3; i++) send_hold(2'd0);
    drain();
    check("t034_preload", score, 12'h995);
    check("t034_sat_pre", sat, 1'b0);
    send_hold(2'd3);
    drain();
    check("t034_score_sat", score, 12'h999);
    check("t034_sat", sat, 1'b1);
    check("t034_level_max", level, 4'hF);
    send_hold(2'd1);
    drain();
    check("t034_score_hold", score, 12'h999);

    // clr during ADD1 with two entries queued.
    step(1'b0, 2'd0, 1'b1);
    send_hold(2'd2);
    drain();
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    step(1'b0, 2'd0, 1'b1);
    check("t035_score", score, 12'h000);
    check("t035_busy", busy, 1'b0);
    check("t035_commit", commit, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 1'b0);

    // Asynchronous reset while in ADD0.
    send_hold(2'd2);
    drain();
    step(1'b1, 2'd3, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("t036_score", score, 12'h000);
    check("t036_lines", lines_total, 12'h000);
    check("t036_level", level, 4'd0);
    check("t036_ready", ev_ready, 1'b1);
    check("t036_busy", busy, 1'b0);
    check("t036_commit", commit, 1'b0);
    model_reset();
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    commit_log.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 1'b0);
    check("t036_no_commit", commit_log.size(), 0);

    // Randomized traffic with occasional restarts.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 199) == 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
